regfile_writeback: RTL
======================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameters SHALL be: I, default 5, register address width; D, default 32, data width.
REQ-002 clk  input  1  single clock; all state SHALL update on the posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  the upstream stage is presenting a writeback.
REQ-005 in_ready  output  1  this block can accept a writeback (combinational, state==RUN).
REQ-006 in_regwrite  input  1  the instruction writes a register.
REQ-007 in_wa  input  I  destination register address.
REQ-008 in_resultsrc  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 illegal.
REQ-009 in_aluresult, in_readdata, in_pcplus4  input  D each  candidate results.
REQ-010 we3  output  1  registered write enable to the register file write port.
REQ-011 wa3  output  I  registered write address.
REQ-012 wd3  output  D  registered write data.
REQ-013 fwd_valid, fwd_addr, fwd_data  output  1/I/D  forwarding copy; SHALL equal we3, wa3, wd3 at all times.
REQ-014 init_done  output  1  high once the register clear sequence has finished.
REQ-015 wb_count  output  16  count of pipeline writes issued, saturating.
REQ-016 sel_err  output  1  sticky flag: an illegal result select was accepted.

Function
REQ-017 States SHALL be INIT and RUN; an internal I-bit counter cnt SHALL drive the clear sequence.
REQ-018 In INIT each posedge SHALL load we3=1, wa3=cnt, wd3=0, then increment cnt; in_ready SHALL be 0.
REQ-019 The posedge that loads wa3=2^I-1 SHALL move the state to RUN and set init_done=1; cnt SHALL NOT wrap to 0, so register 0 is never written.
REQ-020 With I=5 the INIT sequence SHALL be exactly 31 posedges writing addresses 1..31 in ascending order.
REQ-021 In RUN a transfer SHALL occur on a posedge where in_valid=1 and in_ready=1.
REQ-022 On a transfer with in_regwrite=1 and in_wa!=0: we3<=1, wa3<=in_wa, wd3<=selected result; latency SHALL be one cycle from acceptance to we3.
REQ-023 On a transfer with in_regwrite=0 or in_wa=0, and on any RUN posedge with no transfer: we3<=0; wa3 and wd3 SHALL hold their values.
REQ-024 Result select: 00 in_aluresult, 01 in_readdata, 10 in_pcplus4, 11 in_aluresult with sel_err<=1.
REQ-025 sel_err SHALL set only on a transfer carrying select 11, regardless of in_regwrite, and SHALL clear only on reset.
REQ-026 wb_count SHALL increment on each RUN posedge that loads we3=1, and SHALL saturate at 16'hFFFF; INIT writes SHALL NOT count.
REQ-027 in_ready SHALL depend only on the state, never on in_valid.
REQ-028 Output timing: the outputs are registered, so they are stable at the following write-port edge; one write SHALL be presented per cycle.

Reset
REQ-029 While reset=1 at a posedge: state<=INIT, cnt<=1, we3<=0, wa3<=0, wd3<=0, init_done<=0, wb_count<=0, sel_err<=0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abort the current activity and restart the clear sequence from address 1 after release; a transfer presented in the reset cycle SHALL be dropped.

Verification
REQ-031 Release reset -> 31 consecutive cycles with we3=1, wa3=1..31, wd3=0; init_done=1 and in_ready=1 after the 31st edge; no write to address 0.
REQ-032 In RUN, in_valid=1, in_regwrite=1, in_wa=5, sel=01, in_readdata=32'hDEADBEEF -> the next cycle shows we3=1, wa3=5, wd3=32'hDEADBEEF, fwd identical, and wb_count increments by 1.
REQ-033 in_wa=0 with in_regwrite=1, and in_regwrite=0 with in_wa=7 -> we3=0 and wb_count is unchanged in both cases.
REQ-034 sel=11, in_aluresult=32'h12, in_wa=3 -> wd3=32'h12, sel_err=1, which stays 1 through 10 idle cycles.
REQ-035 Back-to-back sel=00/10 to addresses 1 and 2 -> two consecutive write cycles with the correct data each; in_valid=1 during INIT -> no acceptance.
REQ-036 reset pulsed at INIT cycle 10 and at RUN -> the sequence restarts at wa3=1, and wb_count=0 and sel_err=0 afterwards.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback stage: clears registers 1..2^I-1 after reset, then forwards one
// selected result per accepted transfer to the register file write port.
module regfile_writeback #(
  parameter int I = 5,
  parameter int D = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_regwrite,
  input  logic [I-1:0] in_wa,
  input  logic [1:0]   in_resultsrc,
  input  logic [D-1:0] in_aluresult,
  input  logic [D-1:0] in_readdata,
  input  logic [D-1:0] in_pcplus4,
  output logic         we3,
  output logic [I-1:0] wa3,
  output logic [D-1:0] wd3,
  output logic         fwd_valid,
  output logic [I-1:0] fwd_addr,
  output logic [D-1:0] fwd_data,
  output logic         init_done,
  output logic [15:0]  wb_count,
  output logic         sel_err
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [I-1:0] ADDR_ONE  = I'(1);
  localparam logic [I-1:0] ADDR_LAST = {I{1'b1}};
  localparam logic [I-1:0] ADDR_ZERO = {I{1'b0}};

  state_t       state_r;
  logic [I-1:0] cnt_r;
  logic [D-1:0] result_s;

  // Select 11 is illegal; it falls back to the ALU result and is flagged separately.
  function automatic logic [D-1:0] select_result(
    input logic [1:0]   sel,
    input logic [D-1:0] alu,
    input logic [D-1:0] mem,
    input logic [D-1:0] pc4
  );
    logic [D-1:0] r;
    case (sel)
      2'b00:   r = alu;
      2'b01:   r = mem;
      2'b10:   r = pc4;
      default: r = alu;
    endcase
    return r;
  endfunction

  assign result_s  = select_result(in_resultsrc, in_aluresult, in_readdata, in_pcplus4);
  assign in_ready  = (state_r == RUN);
  assign fwd_valid = we3;
  assign fwd_addr  = wa3;
  assign fwd_data  = wd3;

  // Clear-sequence / writeback state machine with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= INIT;
      cnt_r     <= ADDR_ONE;
      we3       <= 1'b0;
      wa3       <= ADDR_ZERO;
      wd3       <= {D{1'b0}};
      init_done <= 1'b0;
      wb_count  <= 16'd0;
      sel_err   <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          we3 <= 1'b1;
          wa3 <= cnt_r;
          wd3 <= {D{1'b0}};
          // Stop on the last address instead of wrapping, so register 0 stays untouched.
          if (cnt_r == ADDR_LAST) begin
            state_r   <= RUN;
            init_done <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ADDR_ONE;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (in_resultsrc == 2'b11) begin
              sel_err <= 1'b1;
            end else begin
              sel_err <= sel_err;
            end
            if (in_regwrite && (in_wa != ADDR_ZERO)) begin
              we3 <= 1'b1;
              wa3 <= in_wa;
              wd3 <= result_s;
              if (wb_count != 16'hFFFF) begin
                wb_count <= wb_count + 16'd1;
              end else begin
                wb_count <= wb_count;
              end
            end else begin
              we3 <= 1'b0;
            end
          end else begin
            we3 <= 1'b0;
          end
        end
        default: begin
          state_r <= INIT;
          cnt_r   <= ADDR_ONE;
          we3     <= 1'b0;
        end
      endcase
    end
  end

endmodule
